// File: rtl/parity_scan_ctrl_if.sv
// Bus bundle for the parity scan controller:
// scan request/results and the store read path.
interface parity_scan_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [DATA_W-1:0] mem_data;
  logic              mem_parity;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   err_count;
  logic              first_err_valid;
  logic [ADDR_W-1:0] first_err_addr;

  modport slave (
    input  start, start_addr, end_addr,
    input  mem_data, mem_parity,
    output mem_addr, mem_en, busy, done,
    output err_count, first_err_valid,
    output first_err_addr
  );

  modport master (
    output start, start_addr, end_addr,
    output mem_data, mem_parity,
    input  mem_addr, mem_en, busy, done,
    input  err_count, first_err_valid,
    input  first_err_addr
  );
endinterface

// File: rtl/parity_scan_ctrl.sv
// Walks an address range of the parity store, one entry per cycle,
// counting parity errors. Option macro: PARITY_SCAN_STOP_ON_ERR_EN.
module parity_scan_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset,
  parity_scan_ctrl_if.slave bus
);

`ifdef PARITY_SCAN_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  localparam logic [ADDR_W:0] ERR_MAX =
    {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_end_addr;
  logic [ADDR_W:0]   r_err_count;
  logic              r_first_valid;
  logic [ADDR_W-1:0] r_first_addr;

  logic [DATA_W-1:0] w_data;
  logic              w_mismatch;
  logic              w_at_end;
  logic              w_accept;
  logic              w_busy;
  logic              w_done;

  assign w_data     = bus.mem_data;
  assign w_mismatch = (^w_data) != bus.mem_parity;
  assign w_at_end   = r_addr == r_end_addr;
  assign w_accept   = (r_state == S_IDLE)
                    && bus.start;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_SCAN;
      end
      S_SCAN: begin
        w_busy = 1'b1;
        if (w_at_end ||
            (STOP_ON_ERR && w_mismatch))
          w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address walk, range latch and error bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr        <= '0;
      r_end_addr    <= '0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_addr  <= '0;
    end else if (w_accept) begin
      r_addr        <= bus.start_addr;
      r_end_addr    <= bus.end_addr;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_addr  <= '0;
    end else if (r_state == S_SCAN) begin
      if (w_mismatch) begin
        if (r_err_count != ERR_MAX)
          r_err_count <= r_err_count + 1'b1;
        if (!r_first_valid) begin
          r_first_valid <= 1'b1;
          r_first_addr  <= r_addr;
        end
      end
      if (w_next == S_SCAN)
        r_addr <= r_addr + 1'b1;
    end
  end

  assign bus.mem_addr        = r_addr;
  assign bus.mem_en          = w_busy;
  assign bus.busy            = w_busy;
  assign bus.done            = w_done;
  assign bus.err_count       = r_err_count;
  assign bus.first_err_valid = r_first_valid;
  assign bus.first_err_addr  = r_first_addr;

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Scoreboard bench for parity_scan_ctrl: a store model drives read data,
// expected addresses and results are queued at start and popped on output.
module tb_parity_scan_ctrl;

  logic clk;
  logic reset;

  parity_scan_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  parity_scan_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem_d [16];
  logic       mem_p [16];

  assign bus.mem_data   = mem_d[bus.mem_addr];
  assign bus.mem_parity = mem_p[bus.mem_addr];

  typedef struct {
    logic [4:0] cnt;
    logic       fv;
    logic [3:0] fa;
    int         lat;
  } exp_t;

  exp_t       res_q [$];
  logic [3:0] addr_q [$];

  int vectors = 0;
  int miscompares = 0;

`ifdef PARITY_SCAN_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  task automatic mem_fill();
    for (int i = 0; i < 16; i++) begin
      mem_d[i] = 8'($urandom);
      mem_p[i] = ^mem_d[i];
    end
  endtask

  task automatic mem_corrupt(input int a);
    mem_p[a] = ~(^mem_d[a]);
  endtask

  // Drives one scan, checks the address stream and final results.
  task automatic run_scan(input logic [3:0] sa,
                          input logic [3:0] ea,
                          input int poke_k);
    exp_t e;
    exp_t g;
    logic [3:0] a;
    logic [3:0] ea_adr;
    int n;
    bit seen;
    e.cnt = '0;
    e.fv  = 1'b0;
    e.fa  = '0;
    a = sa;
    n = 0;
    forever begin
      addr_q.push_back(a);
      n++;
      if ((^mem_d[a]) != mem_p[a]) begin
        if (e.cnt != 5'd16) e.cnt = e.cnt + 5'd1;
        if (!e.fv) begin
          e.fv = 1'b1;
          e.fa = a;
        end
        if (STOP) break;
      end
      if (a == ea) break;
      a = a + 4'd1;
    end
    e.lat = n + 1;
    res_q.push_back(e);

    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = sa;
    bus.end_addr   = ea;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.mem_en) begin
        vectors++;
        if (addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL addr_extra k=%0d got %0d want none",
                   k, bus.mem_addr);
        end else begin
          ea_adr = addr_q.pop_front();
          if (bus.mem_addr !== ea_adr) begin
            miscompares++;
            $display("FAIL mem_addr k=%0d got %0d want %0d",
                     k, bus.mem_addr, ea_adr);
          end
        end
        vectors++;
        if (bus.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy k=%0d got %b want 1", k, bus.busy);
        end
      end
      if (bus.done === 1'b1) begin
        g = res_q.pop_front();
        vectors++;
        if (bus.err_count !== g.cnt) begin
          miscompares++;
          $display("FAIL err_count got %0d want %0d",
                   bus.err_count, g.cnt);
        end
        vectors++;
        if (bus.first_err_valid !== g.fv) begin
          miscompares++;
          $display("FAIL first_err_valid got %b want %b",
                   bus.first_err_valid, g.fv);
        end
        vectors++;
        if (bus.first_err_addr !== g.fa) begin
          miscompares++;
          $display("FAIL first_err_addr got %0d want %0d",
                   bus.first_err_addr, g.fa);
        end
        vectors++;
        if (k != g.lat) begin
          miscompares++;
          $display("FAIL done_latency got %0d want %0d", k, g.lat);
        end
        seen = 1'b1;
        break;
      end
      if (k == poke_k) begin
        bus.start      = 1'b1;
        bus.start_addr = sa + 4'd7;
        bus.end_addr   = ea + 4'd3;
      end else if (k == poke_k + 1) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL done_timeout got none want done");
      res_q.delete();
    end
    vectors++;
    if (addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL addr_missing got %0d left want 0", addr_q.size());
      addr_q.delete();
    end
    @(negedge clk);
    vectors++;
    if ({bus.done, bus.busy, bus.mem_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL post_done got %b want 000",
               {bus.done, bus.busy, bus.mem_en});
    end
    vectors++;
    if (bus.err_count !== e.cnt ||
        bus.first_err_addr !== e.fa) begin
      miscompares++;
      $display("FAIL result_hold got %0d/%0d want %0d/%0d",
               bus.err_count, bus.first_err_addr, e.cnt, e.fa);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.end_addr   = '0;
    #3;
    vectors++;
    if ({bus.mem_addr, bus.mem_en, bus.busy, bus.done,
         bus.err_count, bus.first_err_valid,
         bus.first_err_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %0h want 0",
               {bus.mem_addr, bus.mem_en, bus.busy, bus.done,
                bus.err_count, bus.first_err_valid,
                bus.first_err_addr});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_full();
    mem_fill();
    run_scan(4'd0, 4'd15, 0);
  endtask

  task automatic test_two_errors();
    mem_fill();
    mem_corrupt(3);
    mem_corrupt(11);
    run_scan(4'd0, 4'd15, 0);
  endtask

  task automatic test_wrap();
    mem_fill();
    mem_corrupt(15);
    run_scan(4'd14, 4'd1, 0);
  endtask

  task automatic test_single();
    mem_fill();
    mem_corrupt(5);
    run_scan(4'd5, 4'd5, 0);
  endtask

  task automatic test_full_wrap_all_bad();
    mem_fill();
    for (int i = 0; i < 16; i++) mem_corrupt(i);
    run_scan(4'd9, 4'd8, 0);
  endtask

  task automatic test_start_ignored();
    mem_fill();
    mem_corrupt(7);
    run_scan(4'd2, 4'd10, 3);
  endtask

  task automatic test_back_to_back();
    mem_fill();
    mem_corrupt(1);
    run_scan(4'd0, 4'd3, 0);
    mem_fill();
    run_scan(4'd4, 4'd6, 0);
  endtask

  task automatic test_reset_mid_scan();
    mem_fill();
    mem_corrupt(1);
    mem_corrupt(2);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = 4'd0;
    bus.end_addr   = 4'd15;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1 || bus.err_count !== 5'd2) begin
      miscompares++;
      $display("FAIL pre_reset got %b/%0d want 1/2",
               bus.busy, bus.err_count);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_addr, bus.mem_en, bus.busy, bus.done,
         bus.err_count, bus.first_err_valid,
         bus.first_err_addr} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got %0h want 0",
               {bus.mem_addr, bus.mem_en, bus.busy, bus.done,
                bus.err_count, bus.first_err_valid,
                bus.first_err_addr});
    end
    @(negedge clk);
    reset = 1'b1;
    mem_fill();
    mem_corrupt(12);
    run_scan(4'd10, 4'd13, 0);
  endtask

  initial begin
    test_reset();
    test_clean_full();
    test_two_errors();
    test_wrap();
    test_single();
    test_full_wrap_all_bad();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_scan_ctrl.md
# parity_scan_ctrl

Sequencing controller for the banked parity-protected memory. On a start request it walks an address range of the 16-entry store, one entry per cycle, and checks even parity on each returned word. It counts parity errors and captures the first failing address, then reports completion with a done pulse. It sits between system control and the bank-select/read path, replacing the free-running ripple counter as the address source.

## Interface
- `ADDR_W`, default 4: address width; store depth 2^ADDR_W; MSB selects bank.
- `DATA_W`, default 8: data word width, excluding the parity bit.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous, active-low.
- `start` input 1: scan request, sampled in IDLE only.
- `start_addr` input ADDR_W: first address, latched when start is accepted.
- `end_addr` input ADDR_W: last address (inclusive), latched when start is accepted.
- `mem_addr` output ADDR_W: read address to the store; bit ADDR_W-1 is bank select.
- `mem_en` output 1: high while `mem_addr` is a live read.
- `mem_data` input DATA_W: combinational read data for `mem_addr`.
- `mem_parity` input 1: stored parity bit for `mem_addr`.
- `busy` output 1: high in SCAN.
- `done` output 1: one-cycle pulse at scan completion.
- `err_count` output ADDR_W+1: parity errors found in the last scan.
- `first_err_valid` output 1: at least one error found in the last scan.
- `first_err_addr` output ADDR_W: address of the first error found.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `start`=1 latches `end_addr` into an internal register and loads `mem_addr`←`start_addr`.
  - Clears `err_count`, `first_err_valid` and `first_err_addr`.
  - Transitions to SCAN.
- SCAN:
  - `mem_en`=1.
  - Each cycle, match = (XOR of all `mem_data` bits == `mem_parity`).
  - On a mismatch, `err_count`+1, saturating at 2^ADDR_W.
  - On the first mismatch of the scan, `first_err_addr`←`mem_addr` and `first_err_valid`←1.
  - If `mem_addr` equals the latched end address, go to DONE.
  - Otherwise `mem_addr`←`mem_addr`+1, mod 2^ADDR_W.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Range wrap: `end_addr` < `start_addr` wraps through 2^ADDR_W−1 to 0. `start_addr`==`end_addr` scans one entry. Range length is ((end−start) mod 2^ADDR_W)+1, so a full 16-entry scan uses end = start−1.
- `start` is ignored in SCAN and DONE; no queuing.
- Result outputs hold their values from DONE until the next accepted start.
- `mem_addr` holds its last value in IDLE and DONE with `mem_en`=0.

## Timing
- Start accepted at edge T0. The first address is checked at T1, and the last of N entries at T0+N.
- `done` is high during the cycle following edge T0+N. IDLE is re-entered at edge T0+N+1; a new start is accepted there at the earliest.
- Throughput: one entry per cycle; no wait states. `mem_data` must settle within one cycle of the `mem_addr` change.
- `busy` rises after T0 and falls after T0+N.
- `err_count` and `first_err_*` are updated at the same edge as the entry's check, and are final when `done` is high.
- Reset (`reset`=0) at any time, including mid-scan, immediately forces IDLE with:
  - `mem_addr`=0, `mem_en`=0, `busy`=0, `done`=0.
  - `err_count`=0, `first_err_valid`=0, `first_err_addr`=0.
- No partial results survive reset.

## Configuration
- `PARITY_SCAN_STOP_ON_ERR_EN`
  - Defined: the first mismatch ends the scan at that edge. The next state is DONE, `err_count`=1, `first_err_addr` = the failing address, and `busy` falls one cycle later.
  - Undefined: the scan always covers the full range and counts every error.

## Test plan
- All 16 entries correct, `start_addr`=0, `end_addr`=15 → `done` 17 cycles after start, `err_count`=0, `first_err_valid`=0.
- Parity corrupted at addresses 3 and 11, full range → `err_count`=2, `first_err_addr`=3, `first_err_valid`=1. Same stimulus with the macro defined → DONE after 4 cycles, `err_count`=1, `first_err_addr`=3.
- Wrap: `start_addr`=14, `end_addr`=1 → `mem_addr` sequence 14, 15, 0, 1, then `done`. The bank bit toggles 1→0 between 15 and 0.
- Single entry: `start_addr`=`end_addr`=5 with a bad entry → one SCAN cycle, `err_count`=1, `first_err_addr`=5.
- `start` pulsed again mid-scan with different addresses → ignored. The original range completes and the latched end address is unchanged.
- `reset` asserted at the 6th SCAN cycle → all outputs return to reset values asynchronously. After release, `start` begins a fresh scan with `err_count`=0.
